macrocell_cfg_loader: RTL and testbench
=======================================

Name: macrocell_cfg_loader

Overview:
- Serial configuration loader that produces the per-macrocell mux-select fuses `xor_inv_mux`, `o_mux` and `d_mux`, which the macrocell XOR/D-path logic consumes.
- Accepts a framed, parity-protected fuse bitstream over a valid/ready handshake and stages it in a shadow register.
- Commits the shadow register atomically to the live select outputs only when every frame passes parity.
- Sits between the ISP/bitstream front end and the array of macrocells.

Parameters:
- NUM_MC, 16: number of macrocells configured; must be ≥ 1.
- MCW, 5: width of the macrocell index counter; must satisfy 2^MCW ≥ NUM_MC.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE.
- abort  input  1  cancel a load in progress; sampled only in SHIFT.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial fuse bit.
- cfg_ready  output  1  loader accepts a bit this cycle.
- xor_inv_mux  output  NUM_MC  live XOR/XNOR select, one bit per macrocell.
- o_mux  output  NUM_MC  live y2/q (dfast) select per macrocell.
- d_mux  output  NUM_MC  live D-source select per macrocell.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.
- err  output  1  parity failure flag for the last load; sticky until the next start.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - xor_inv_mux, o_mux, d_mux, shadow, counters, done and err all go to 0.
  - The all-zero selects route XNOR, q and the y2q path.
  - Reset asserted mid-load discards the partial load.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 → SHIFT at the next edge.
  - On that edge: bit_cnt=0, mc_idx=0, err=0, shadow cleared.
- SHIFT:
  - busy=1.
  - cfg_ready = ~abort.
  - A bit is accepted on an edge where cfg_valid & cfg_ready.
  - start is ignored.
- Frame format (4 accepted bits per macrocell, macrocell 0 first):
  - bit0 = xor_inv_mux
  - bit1 = o_mux
  - bit2 = d_mux
  - bit3 = parity
  - Odd parity: the XOR of all four bits must be 1.
- Frame handling:
  - bits 0–2 are held in a frame buffer.
  - On acceptance of bit3, the parity check runs.
  - Parity pass: shadow[mc_idx] is written.
  - Parity fail: err is set and shadow[mc_idx] is left 0.
  - Either way, mc_idx increments and bit_cnt wraps to 0.
- Last frame (bit3 of macrocell NUM_MC-1 accepted):
  - On the same edge, if the err value after this frame's check is 0, all three live outputs load from shadow, including the final frame.
  - State → DONE.
- DONE:
  - done=1 for exactly one cycle; err is valid at the same time.
  - → IDLE at the next edge.
- Commit is all-or-nothing. On any parity error the live outputs keep their previous values.
- Abort:
  - abort=1 in SHIFT → IDLE at the next edge.
  - No done pulse; live outputs unchanged; err keeps its current value.
  - When abort and cfg_valid are both high in the same cycle, abort wins and the bit is not accepted.
- abort is ignored in IDLE and in DONE.
- cfg_valid=0 cycles in SHIFT stall the load with no timeout; counters hold.
- Latency:
  - Minimum load time is 4*NUM_MC accepted cycles.
  - done is asserted in the cycle immediately after the final accepted bit.
  - Live outputs change on that same edge.
- start in DONE is ignored. A new load requires start in IDLE.

Test Plan:
- Reset value: hold rst_n=0, then release → xor_inv_mux=o_mux=d_mux=0, cfg_ready=0, busy=0, done=0, err=0.
- Clean load (NUM_MC=2): start, then stream mc0 = 1,0,1,1 and mc1 = 0,1,1,1 with cfg_valid held high.
  - During the 8 accepted cycles: busy=1.
  - Next cycle: done=1, err=0, xor_inv_mux=2'b01, o_mux=2'b10, d_mux=2'b11.
- Parity error: after the clean load, stream mc0 = 0,0,0,0 (bad parity) and mc1 = 1,1,1,0.
  - done=1 and err=1.
  - Live outputs remain 01/10/11.
- Stall and abort:
  - Start, accept 5 bits with cfg_valid gaps → counters hold across the gaps.
  - Then drive abort=1 together with cfg_valid=1 → cfg_ready=0 that cycle and the bit is not accepted.
  - Next: IDLE, no done pulse, outputs unchanged.
- Async reset mid-load: drop rst_n after 6 accepted bits, without waiting for a clock edge → outputs clear immediately.
  - A following clean load completes normally.
- Ignored start: pulse start during SHIFT and during DONE → no restart and no counter reset.
  - The load completes with the expected values.

Source files
------------

// File: rtl/macrocell_cfg_loader.sv
// Serial fuse loader for the macrocell XOR/D-path selects: parity-checked frames are
// staged in a shadow register and committed to the live selects only if every frame passes.
module macrocell_cfg_loader #(
  parameter int NUM_MC = 16,
  parameter int MCW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  output logic [NUM_MC-1:0] xor_inv_mux,
  output logic [NUM_MC-1:0] o_mux,
  output logic [NUM_MC-1:0] d_mux,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        bit_cnt, bit_cnt_nxt;
  logic [MCW-1:0]    mc_idx, mc_idx_nxt;
  logic [2:0]        frame_buf, frame_buf_nxt;
  logic [NUM_MC-1:0] sh_xor, sh_xor_nxt;
  logic [NUM_MC-1:0] sh_o, sh_o_nxt;
  logic [NUM_MC-1:0] sh_d, sh_d_nxt;
  logic [NUM_MC-1:0] live_xor_nxt, live_o_nxt, live_d_nxt;
  logic              err_nxt;

  function automatic logic odd_parity(input logic [3:0] frame);
    return ^frame;
  endfunction

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign cfg_ready = (state == SHIFT) && !abort;

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    mc_idx_nxt    = mc_idx;
    frame_buf_nxt = frame_buf;
    sh_xor_nxt    = sh_xor;
    sh_o_nxt      = sh_o;
    sh_d_nxt      = sh_d;
    live_xor_nxt  = xor_inv_mux;
    live_o_nxt    = o_mux;
    live_d_nxt    = d_mux;
    err_nxt       = err;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = 2'd0;
          mc_idx_nxt  = '0;
          err_nxt     = 1'b0;
          sh_xor_nxt  = '0;
          sh_o_nxt    = '0;
          sh_d_nxt    = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cfg_valid) begin
          if (bit_cnt != 2'd3) begin
            // Shift right so that after three data bits frame_buf = {d, o, xor}.
            frame_buf_nxt = {cfg_bit, frame_buf[2:1]};
            bit_cnt_nxt   = bit_cnt + 2'd1;
          end else begin
            if (odd_parity({cfg_bit, frame_buf})) begin
              for (int i = 0; i < NUM_MC; i++) begin
                if (mc_idx == MCW'(i)) begin
                  sh_xor_nxt[i] = frame_buf[0];
                  sh_o_nxt[i]   = frame_buf[1];
                  sh_d_nxt[i]   = frame_buf[2];
                end
              end
            end else begin
              err_nxt = 1'b1;
            end
            bit_cnt_nxt = 2'd0;
            mc_idx_nxt  = mc_idx + MCW'(1);
            if (mc_idx == MCW'(NUM_MC - 1)) begin
              state_nxt = DONE;
              // Commit includes the frame checked on this very edge.
              if (!err_nxt) begin
                live_xor_nxt = sh_xor_nxt;
                live_o_nxt   = sh_o_nxt;
                live_d_nxt   = sh_d_nxt;
              end
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 2'd0;
      mc_idx      <= '0;
      frame_buf   <= 3'd0;
      sh_xor      <= '0;
      sh_o        <= '0;
      sh_d        <= '0;
      xor_inv_mux <= '0;
      o_mux       <= '0;
      d_mux       <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      mc_idx      <= mc_idx_nxt;
      frame_buf   <= frame_buf_nxt;
      sh_xor      <= sh_xor_nxt;
      sh_o        <= sh_o_nxt;
      sh_d        <= sh_d_nxt;
      xor_inv_mux <= live_xor_nxt;
      o_mux       <= live_o_nxt;
      d_mux       <= live_d_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_macrocell_cfg_loader.sv
// Bench for macrocell_cfg_loader: table-driven loads, abort/reset sequences and
// randomized loads checked against a frame-level reference model.
module tb_macrocell_cfg_loader;
  localparam int NUM_MC = 2;
  localparam int MCW    = 2;
  localparam int NB     = 4 * NUM_MC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_bit = 1'b0;
  logic cfg_ready, busy, done, err;
  logic [NUM_MC-1:0] xor_inv_mux, o_mux, d_mux;

  macrocell_cfg_loader #(.NUM_MC(NUM_MC), .MCW(MCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_ready(cfg_ready),
    .xor_inv_mux(xor_inv_mux), .o_mux(o_mux), .d_mux(d_mux),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [NUM_MC-1:0] exp_x = '0;
  logic [NUM_MC-1:0] exp_o = '0;
  logic [NUM_MC-1:0] exp_d = '0;
  logic              exp_err = 1'b0;

  typedef struct {
    logic [NB-1:0]     stream;
    logic [NUM_MC-1:0] x, o, d;
    logic              e;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_live(input string tag);
    chk({tag, "_xor"}, 32'(xor_inv_mux), 32'(exp_x));
    chk({tag, "_o"},   32'(o_mux),       32'(exp_o));
    chk({tag, "_d"},   32'(d_mux),       32'(exp_d));
    chk({tag, "_err"}, 32'(err),         32'(exp_err));
  endtask

  // Frame k of the stream occupies bits [4k+3:4k]; bit 4k is sent first.
  task automatic model_load(input logic [NB-1:0] s);
    logic [NUM_MC-1:0] nx, no, nd;
    logic [3:0] f;
    logic bad;
    nx = '0; no = '0; nd = '0; bad = 1'b0;
    for (int m = 0; m < NUM_MC; m++) begin
      f = s[4*m +: 4];
      if (^f) begin
        nx[m] = f[0]; no[m] = f[1]; nd[m] = f[2];
      end else begin
        bad = 1'b1;
      end
    end
    exp_err = bad;
    if (!bad) begin
      exp_x = nx; exp_o = no; exp_d = nd;
    end
  endtask

  task automatic run_load(input logic [NB-1:0] s, input bit gaps, input bit poke_start);
    int g;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < NB; j++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) begin
        cfg_valid = 1'b0;
        start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        chk("busy_gap", 32'(busy), 32'd1);
      end
      cfg_valid = 1'b1;
      cfg_bit = s[j];
      start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk("ready_shift", 32'(cfg_ready), 32'd1);
      chk("busy_shift", 32'(busy), 32'd1);
      chk("done_shift", 32'(done), 32'd0);
      step();
    end
    cfg_valid = 1'b0;
    start = poke_start;
    model_load(s);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    check_live("commit");
    step();
    start = 1'b0;
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ready_idle", 32'(cfg_ready), 32'd0);
  endtask

  initial begin
    logic [NB-1:0] s;
    logic [2:0] b;

    tbl[0] = '{stream: {4'b1110, 4'b1101}, x: 2'b01, o: 2'b10, d: 2'b11, e: 1'b0};
    tbl[1] = '{stream: {4'b0111, 4'b0000}, x: 2'b01, o: 2'b10, d: 2'b11, e: 1'b1};
    tbl[2] = '{stream: {4'b1011, 4'b0010}, x: 2'b10, o: 2'b11, d: 2'b00, e: 1'b0};
    tbl[3] = '{stream: {4'b1100, 4'b0111}, x: 2'b10, o: 2'b11, d: 2'b00, e: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_live("in_reset");
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    check_live("after_reset");
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy2", 32'(busy), 32'd0);

    // Table-driven loads
    for (int i = 0; i < 4; i++) begin
      run_load(tbl[i].stream, 1'b0, 1'b0);
      chk("tbl_xor", 32'(xor_inv_mux), 32'(tbl[i].x));
      chk("tbl_o",   32'(o_mux),       32'(tbl[i].o));
      chk("tbl_d",   32'(d_mux),       32'(tbl[i].d));
      chk("tbl_err", 32'(err),         32'(tbl[i].e));
    end

    // Stall then abort: frame 0 is bad, so err must survive the abort
    s = {4'b0001, 4'b0000};
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cfg_valid = 1'b0;
      step();
      chk("busy_stall", 32'(busy), 32'd1);
      cfg_valid = 1'b1;
      cfg_bit = s[j];
      step();
    end
    abort = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit = 1'b1;
    #1;
    chk("abort_ready", 32'(cfg_ready), 32'd0);
    step();
    abort = 1'b0;
    cfg_valid = 1'b0;
    exp_err = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    check_live("abort");
    step();
    chk("abort_done2", 32'(done), 32'd0);

    // abort has no effect in IDLE
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    check_live("idle_abort");

    // Randomized loads with gaps and stray start pulses
    for (int n = 0; n < 25; n++) begin
      for (int m = 0; m < NUM_MC; m++) begin
        b = 3'($urandom);
        s[4*m +: 3] = b;
        s[4*m + 3] = ($urandom_range(0, 3) == 0) ? (^b) : ~(^b);
      end
      run_load(s, 1'b1, n[0]);
    end

    // Async reset mid-load, after a commit that leaves nonzero selects
    run_load(tbl[0].stream, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cfg_valid = 1'b1;
      cfg_bit = tbl[2].stream[j];
      step();
    end
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_x = '0; exp_o = '0; exp_d = '0; exp_err = 1'b0;
    check_live("async_rst");
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(cfg_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_load(tbl[2].stream, 1'b1, 1'b1);
    chk("post_rst_xor", 32'(xor_inv_mux), 32'(tbl[2].x));
    chk("post_rst_o",   32'(o_mux),       32'(tbl[2].o));
    chk("post_rst_d",   32'(d_mux),       32'(tbl[2].d));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
